// File: rtl/tampon_tx_uart.sv
// Byte FIFO and transmit sequencer in front of uart_tx.
// Drains queued bytes in order, one frame at a time, and reports fill level and overflow.
module tampon_tx_uart #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    StIdle,
    StWaitDone
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              tx_start_q;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              push_ok;
  logic              pop;

  assign full     = (count_q == FullCount);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  // Acceptance uses the registered full, so a pop in the same cycle never frees a slot early.
  assign push_ok = wr_en && !full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !tx_active) begin
          pop     = 1'b1;
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (tx_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // A dropped push in the same cycle as clr_ovf keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    tx_data_d = tx_data_q;
    if (pop) begin
      tx_data_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      tx_start_q <= pop;
      tx_data_q  <= tx_data_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_tampon_tx_uart.sv
// Self-checking bench for tampon_tx_uart: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model with an emulated uart_tx.
module tb_tampon_tx_uart;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              clr_ovf;
  logic              tx_active;
  logic              tx_done;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;

  tampon_tx_uart #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_ovf   (clr_ovf),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stored bytes, whether a frame is outstanding, sticky overflow.
  logic [7:0] ref_q[$];
  bit         model_wait;
  bit         ovf_m;
  logic [7:0] last_byte;
  // uart_tx emulation: remaining active cycles and a pending done pulse.
  int         ucnt;
  bit         udone;
  bit         auto_uart;
  bit         blip_en;

  typedef struct packed {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_active;
    logic       tx_done;
    logic       e_start;
    logic [7:0] e_data;
    logic [4:0] e_count;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    ref_q.delete();
    model_wait = 0;
    ovf_m      = 0;
    last_byte  = 8'h00;
    ucnt       = 0;
    udone      = 0;
  endtask

  // One clock: drive the emulated uart, advance, then compare against the model.
  task automatic tick();
    int         pre_size;
    bit         exp_start;
    bit         push_acc;
    bit         drop;
    bit         done_seen;
    logic [7:0] wd;
    logic [7:0] exp_byte;
    if (auto_uart) begin
      if (ucnt > 0) begin
        tx_active = 1'b1;
        tx_done   = 1'b0;
        ucnt--;
        if (ucnt == 0) udone = 1;
      end else if (udone) begin
        tx_active = 1'b0;
        tx_done   = 1'b1;
        udone     = 0;
      end else begin
        tx_active = blip_en && ($urandom_range(0, 9) == 0);
        tx_done   = blip_en && ($urandom_range(0, 9) == 0);
      end
    end
    wd        = wr_data;
    pre_size  = ref_q.size();
    push_acc  = wr_en && (pre_size < DEPTH);
    drop      = wr_en && (pre_size == DEPTH);
    exp_start = !model_wait && (pre_size > 0) && !tx_active;
    done_seen = model_wait && tx_done;
    ovf_m     = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_m);
    @(posedge clk);
    #1;
    check("tx_start", tx_start, exp_start);
    if (exp_start) begin
      exp_byte   = ref_q.pop_front();
      last_byte  = exp_byte;
      model_wait = 1;
      if (auto_uart) ucnt = $urandom_range(1, 6);
    end
    if (done_seen) model_wait = 0;
    if (push_acc) ref_q.push_back(wd);
    check("tx_data", tx_data, last_byte);
    check("count", count, ref_q.size());
    check("full", full, ref_q.size() == DEPTH);
    check("empty", empty, ref_q.size() == 0);
    check("overflow", overflow, ovf_m);
  endtask

  task automatic drain(input int budget);
    int n;
    n       = 0;
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    while ((ref_q.size() != 0 || model_wait || ucnt != 0 || udone) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", (ref_q.size() == 0) && !model_wait, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] menu [4];
    int         peak;
    menu = '{8'h4D, 8'h45, 8'h4E, 8'h55};
    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
    tx_active = 1'b0; tx_done = 1'b0; auto_uart = 0; blip_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;

    // {wr_en, wr_data, tx_active, tx_done} -> {tx_start, tx_data, count}
    vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 5'd0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 5'd0};
    vecs[3]  = '{1'b1, 8'h4D, 1'b1, 1'b0, 1'b0, 8'h41, 5'd1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 5'd1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h4D, 5'd0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h4D, 5'd0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h4D, 5'd0};
    vecs[8]  = '{1'b1, 8'h45, 1'b1, 1'b0, 1'b0, 8'h4D, 5'd1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h4D, 5'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h45, 5'd0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h45, 5'd0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h45, 5'd0};
    for (int i = 0; i < 13; i++) begin
      wr_en     = vecs[i].wr_en;
      wr_data   = vecs[i].wr_data;
      tx_active = vecs[i].tx_active;
      tx_done   = vecs[i].tx_done;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_tx_start", i), tx_start, vecs[i].e_start);
      check($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].e_data);
      check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
    end
    wr_en = 1'b0; tx_active = 1'b0; tx_done = 1'b0;
    last_byte = 8'h45;

    // Reset mid-frame: three bytes pushed, first already started, then async reset.
    wr_en = 1'b1; wr_data = 8'hA1; tick();
    wr_data = 8'hA2; tick();
    wr_data = 8'hA3; tick();
    wr_en = 1'b0; tx_active = 1'b1;
    tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_tx_start", tx_start, 0);
    check("async_rst_tx_data", tx_data, 8'h00);
    check("async_rst_count", count, 0);
    check("async_rst_empty", empty, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    tx_active = 1'b0; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (10) tick();
    check("post_rst_count", count, 0);

    // Single byte, done delivered 50 cycles later, then the FSM must be idle again.
    wr_en = 1'b1; wr_data = 8'h41; tick();
    wr_en = 1'b0; tick();
    check("single_start", tx_start, 1);
    check("single_data", tx_data, 8'h41);
    tx_active = 1'b1;
    repeat (50) tick();
    tx_active = 1'b0; tx_done = 1'b1; tick();
    tx_done = 1'b0;
    wr_en = 1'b1; wr_data = 8'h42; tick();
    wr_en = 1'b0; tick();
    check("after_done_start", tx_start, 1);
    tx_done = 1'b1; tick();
    tx_done = 1'b0; tick();

    // MENU burst with the emulated uart draining.
    auto_uart = 1;
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = menu[i];
      tick();
      if (int'(count) > peak) peak = int'(count);
    end
    check("menu_peak", (peak >= 3) && (peak <= 4), 1);
    drain(300);

    // Fill to full with the uart busy; the 17th byte is dropped.
    auto_uart = 0; tx_active = 1'b1; tx_done = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_overflow", overflow, 1);
    wr_en = 1'b0; clr_ovf = 1'b1; tick();
    check("clr_overflow", overflow, 0);
    wr_en = 1'b1; wr_data = 8'h99; tick();
    check("drop_beats_clr", overflow, 1);
    clr_ovf = 1'b0;
    auto_uart = 1;
    wr_data = 8'h77; tick();
    check("pop_full_push_drop", count, 15);
    check("pop_full_first", tx_data, 8'h00);
    drain(400);
    check("drained_empty", empty, 1);
    clr_ovf = 1'b1; tick();
    clr_ovf = 1'b0;
    check("final_clr_overflow", overflow, 0);

    // Wrap: 20 bytes, with a simultaneous push and pop at count 1.
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hB0 + i);
      tick();
      if (i == 1) check("simul_push_pop_count", count, 1);
    end
    drain(400);

    // Randomized traffic with spurious tx_active/tx_done while idle.
    blip_en = 1;
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom_range(0, 9) < 4);
      wr_data = 8'($urandom);
      clr_ovf = ($urandom_range(0, 19) == 0);
      tick();
    end
    blip_en = 0;
    drain(600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
